// File: rtl/cg_ctrl_pkg.sv
// Shared types and constants for the clock-gate enable controller.
package cg_ctrl_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_COUNT = 2'd1,
        CG_SLEEP = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    localparam int CG_STATS_WIDTH = 32;

endpackage

// File: rtl/cg_enable_ctrl_if.sv
// Activity/request inputs and gate-control outputs of cg_enable_ctrl.
// Signal suffixes are from the controller's point of view (slave modport).
interface cg_enable_ctrl_if
    import cg_ctrl_pkg::*;
#(
    parameter int IDLE_CNT_WIDTH = 8
) ();

    logic                      busy_i;
    logic                      req_i;
    logic                      sleep_allow_i;
    logic [IDLE_CNT_WIDTH-1:0] idle_thresh_i;
    logic                      stats_clr_i;
    logic                      clk_en_o;
    logic                      ready_o;
    logic                      sleeping_o;
    logic [CG_STATS_WIDTH-1:0] sleep_cycles_o;

    modport master (
        output busy_i, req_i, sleep_allow_i, idle_thresh_i, stats_clr_i,
        input  clk_en_o, ready_o, sleeping_o, sleep_cycles_o
    );

    modport slave (
        input  busy_i, req_i, sleep_allow_i, idle_thresh_i, stats_clr_i,
        output clk_en_o, ready_o, sleeping_o, sleep_cycles_o
    );

endinterface

// File: rtl/cg_sat_counter.sv
// Generic clearable up-counter that holds at its all-ones value.
module cg_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cg_enable_ctrl.sv
// Idle-detect / wake controller driving the clock-gate enable, on the ungated clock.
// Optional sleep-cycle statistics are built when CG_CTRL_STATS_EN is defined.
module cg_enable_ctrl
    import cg_ctrl_pkg::*;
#(
    parameter int IDLE_CNT_WIDTH = 8,
    parameter int WAKE_LAT       = 2
) (
    input logic             clk_i,
    input logic             rst_i,
    cg_enable_ctrl_if.slave ctrl
);

    localparam int WCNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((WAKE_LAT > 0) ? WAKE_LAT - 1 : 0);

    cg_state_e                 state_q, state_d;
    logic [IDLE_CNT_WIDTH-1:0] icnt_q, icnt_d;
    logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
    logic                      idle;

    assign idle = ctrl.sleep_allow_i & ~ctrl.busy_i & ~ctrl.req_i;

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            CG_RUN: begin
                if (idle) begin
                    state_d = CG_COUNT;
                    icnt_d  = '0;
                end
            end
            CG_COUNT: begin
                // Activity has priority over a threshold match.
                if (!idle) begin
                    state_d = CG_RUN;
                    icnt_d  = '0;
                end else if (icnt_q >= ctrl.idle_thresh_i) begin
                    state_d = CG_SLEEP;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end
            CG_SLEEP: begin
                if (!idle) begin
                    state_d = (WAKE_LAT == 0) ? CG_RUN : CG_WAKE;
                    wcnt_d  = '0;
                end
            end
            CG_WAKE: begin
                // Settle time runs to completion even if the block goes idle again.
                if (wcnt_q == WCNT_LAST) begin
                    state_d = CG_RUN;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = CG_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CG_RUN;
            icnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Outputs decode the state register only, so the enable never glitches mid-cycle.
    assign ctrl.clk_en_o   = (state_q != CG_SLEEP);
    assign ctrl.ready_o    = (state_q == CG_RUN) || (state_q == CG_COUNT);
    assign ctrl.sleeping_o = (state_q == CG_SLEEP);

`ifdef CG_CTRL_STATS_EN
    cg_sat_counter #(
        .WIDTH (CG_STATS_WIDTH)
    ) u_sleep_stats (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (ctrl.stats_clr_i),
        .inc_i (state_q == CG_SLEEP),
        .cnt_o (ctrl.sleep_cycles_o)
    );
`else
    logic unused_stats_clr;
    assign unused_stats_clr    = ctrl.stats_clr_i;
    assign ctrl.sleep_cycles_o = '0;
`endif

endmodule
